cache_axi_bridge: RTL and testbench
===================================

// Module: cache_axi_bridge
// PURPOSE
// Memory-side sequencer for the cache core. Turns cache line write-back and line-load requests into single AXI4 INCR bursts of one line.
// Sits between the cache controller's memory/write-back/load interfaces and the AXI4 interconnect; one transaction in flight.
// PARAMETERS
// ADDR_SIZE   32  address width
// DATA_SIZE   32  beat width, power of 2, >=8
// BLOCK_SIZE  6   log2 line bytes; localparams BLOCKS=2**BLOCK_SIZE/(DATA_SIZE/8) (16), BEAT_W=$clog2(BLOCKS)
// PORTS
// clk            in   1                  clock
// rst_n          in   1                  synchronous, active-low reset
// addr_valid_in  in   1                  memory request from cache controller
// addr_ready     out  1                  high in IDLE; request accepted when both high
// addr_in        in   ADDR_SIZE          request address, low BLOCK_SIZE bits ignored
// rw_in          in   1                  1=write-back line, 0=load line
// valid_wb       in   1                  write-back line valid
// ready_wb       out  1                  1-cycle pulse: line captured
// data_wb        in   BLOCKS*DATA_SIZE   line to write, word 0 in LSBs
// valid_ld       out  1                  loaded line available
// ready_ld       in   1                  cache accepts loaded line
// data_ld        out  BLOCKS*DATA_SIZE   loaded line, word 0 in LSBs
// bus_err        out  1                  sticky: non-OKAY resp or rlast mismatch
// axi_awvalid/axi_awready  out/in  1     write address handshake
// axi_awaddr     out  ADDR_SIZE          line-aligned address
// axi_awlen/awsize/awburst out 8/3/2     BLOCKS-1, $clog2(DATA_SIZE/8), 2'b01
// axi_wvalid/axi_wready    out/in  1     write data handshake
// axi_wdata      out  DATA_SIZE          beat data
// axi_wstrb      out  DATA_SIZE/8        all ones
// axi_wlast      out  1                  last beat
// axi_bvalid/axi_bready    in/out  1     write response handshake
// axi_bresp      in   2                  write response
// axi_arvalid/axi_arready  out/in  1     read address handshake
// axi_araddr     out  ADDR_SIZE          line-aligned address
// axi_arlen/arsize/arburst out 8/3/2     same values as AW
// axi_rvalid/axi_rready    in/out  1     read data handshake
// axi_rdata      in   DATA_SIZE          beat data
// axi_rresp/axi_rlast      in   2/1      read response, last flag
// BEHAVIOUR
// - FSM IDLE,AW,W,B,AR,R,LD. Reset: IDLE, every valid/ready output 0 except addr_ready=1, bus_err=0, beat=0.
// - IDLE accept: write only when valid_wb=1 too -> line into buffer, ready_wb=1 that cycle, addr&~(2**BLOCK_SIZE-1) latched, ->AW. Read ->AR.
// - AW/AR: valid held, addr stable until ready; ->W / ->R. valids never depend on readies.
// - W: wvalid=1, wdata=buf[beat], wlast=(beat==BLOCKS-1); beat++ on wvalid&wready; after last ->B, beat wraps to 0.
// - B: bready=1; on bvalid ->IDLE; bresp!=2'b00 sets bus_err.
// - R: rready=1; on rvalid buf[beat]<=rdata, beat++; rresp!=0 or rlast!=(beat==BLOCKS-1) sets bus_err; exactly BLOCKS beats consumed, then ->LD.
// - LD: valid_ld=1, data_ld=buf stable until ready_ld; ->IDLE. Line delivered even on error.
// - Min latency (accept at cycle N, slaves always ready): arvalid N+1, R beats N+2..N+1+BLOCKS, valid_ld N+2+BLOCKS; wvalid N+2..N+1+BLOCKS, bready N+2+BLOCKS.
// - Requests while busy are not accepted (addr_ready=0); cache controller sequences write-back then load.
// - rst_n low mid-burst: next edge IDLE, all AXI valids 0; burst abandoned (interconnect shares reset). bus_err cleared only by reset.
// TESTING
// 1. Load addr 0x1234, slaves always ready, rdata=beat idx -> araddr 0x1200, arlen 15, arsize 2, valid_ld at N+18, data_ld word k = k.
// 2. Write-back 0x8000_0040, word k=0xA0+k, wready toggling -> 16 ordered beats, wlast on 16th only, single ready_wb pulse, IDLE after bvalid.
// 3. Write request with valid_wb=0 for 5 cycles -> no ready_wb, no awvalid; accepted the cycle valid_wb rises.
// 4. awready=0 for 10 cycles -> awvalid/awaddr stable, wvalid 0; ready_ld=0 for 4 cycles -> data_ld stable.
// 5. rresp=2'b10 on beat 3, then separate load with rlast on beat 7 -> bus_err=1 and stays; 16 beats still taken, line delivered.
// 6. rst_n=0 during W beat 5 -> next cycle all valids 0, addr_ready=1 after release; following load completes correctly.

Source files
------------

// File: rtl/cache_axi_bridge_if.sv
// AXI4 master-side bus bundle for the cache memory bridge.
// The bridge uses the master modport; a memory model or interconnect uses the slave modport.
interface cache_axi_bridge_if #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;

    logic                   wvalid;
    logic                   wready;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;
    logic                   wlast;

    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;

    logic                   arvalid;
    logic                   arready;
    logic [ADDR_SIZE-1:0]   araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;

    logic                   rvalid;
    logic                   rready;
    logic [DATA_SIZE-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// Memory-side sequencer for the cache: turns one line write-back or line load
// into a single AXI4 INCR burst of one line. One transaction in flight.
module cache_axi_bridge #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_SIZE  = 32,
    parameter int BLOCK_SIZE = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            addr_valid_in,
    output logic                            addr_ready,
    input  logic [ADDR_SIZE-1:0]            addr_in,
    input  logic                            rw_in,
    input  logic                            valid_wb,
    output logic                            ready_wb,
    input  logic [8*(2**BLOCK_SIZE)-1:0]    data_wb,
    output logic                            valid_ld,
    input  logic                            ready_ld,
    output logic [8*(2**BLOCK_SIZE)-1:0]    data_ld,
    output logic                            bus_err,
    cache_axi_bridge_if.master              axi
);
    localparam int BLOCKS = (2**BLOCK_SIZE) / (DATA_SIZE/8);
    localparam int BEAT_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ADDR_SIZE'((2**BLOCK_SIZE) - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_LD} state_t;

    state_t                 state, state_nx;
    logic [BEAT_W-1:0]      beat;
    logic                   last_beat;
    logic                   accept;
    logic [ADDR_SIZE-1:0]   line_addr;
    logic [DATA_SIZE-1:0]   line_buf [BLOCKS];

    assign last_beat = (beat == BEAT_W'(BLOCKS - 1));

    // Burst attributes are fixed: one full line, INCR, full-width beats.
    assign axi.awaddr  = line_addr;
    assign axi.awlen   = 8'(BLOCKS - 1);
    assign axi.awsize  = 3'($clog2(DATA_SIZE/8));
    assign axi.awburst = 2'b01;
    assign axi.araddr  = line_addr;
    assign axi.arlen   = 8'(BLOCKS - 1);
    assign axi.arsize  = 3'($clog2(DATA_SIZE/8));
    assign axi.arburst = 2'b01;
    assign axi.wdata   = line_buf[beat];
    assign axi.wstrb   = '1;
    assign axi.wlast   = last_beat;

    for (genvar k = 0; k < BLOCKS; k++) begin : g_ld
        assign data_ld[k*DATA_SIZE +: DATA_SIZE] = line_buf[k];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs; valids depend only on state, never on readies.
    always_comb begin
        state_nx    = state;
        addr_ready  = 1'b0;
        ready_wb    = 1'b0;
        accept      = 1'b0;
        valid_ld    = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        case (state)
            S_IDLE: begin
                addr_ready = 1'b1;
                if (addr_valid_in) begin
                    if (rw_in) begin
                        // A write-back waits here until its line is presented.
                        if (valid_wb) begin
                            ready_wb = 1'b1;
                            accept   = 1'b1;
                            state_nx = S_AW;
                        end
                    end else begin
                        accept   = 1'b1;
                        state_nx = S_AR;
                    end
                end
            end
            S_AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) state_nx = S_W;
            end
            S_W: begin
                axi.wvalid = 1'b1;
                if (axi.wready && last_beat) state_nx = S_B;
            end
            S_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) state_nx = S_IDLE;
            end
            S_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_nx = S_R;
            end
            S_R: begin
                axi.rready = 1'b1;
                // Exactly one line of beats is consumed regardless of rlast.
                if (axi.rvalid && last_beat) state_nx = S_LD;
            end
            S_LD: begin
                valid_ld = 1'b1;
                if (ready_ld) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Beat counter and sticky bus error; only reset can clear bus_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat    <= '0;
            bus_err <= 1'b0;
        end else begin
            if ((state == S_W && axi.wready) || (state == S_R && axi.rvalid))
                beat <= last_beat ? '0 : beat + 1'b1;
            if (state == S_B && axi.bvalid && axi.bresp != 2'b00)
                bus_err <= 1'b1;
            if (state == S_R && axi.rvalid && (axi.rresp != 2'b00 || axi.rlast != last_beat))
                bus_err <= 1'b1;
        end
    end

    // Line buffer and aligned address; pure data, not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_addr <= addr_in & ~LINE_MASK;
            if (rw_in) begin
                for (int k = 0; k < BLOCKS; k++)
                    line_buf[k] <= data_wb[k*DATA_SIZE +: DATA_SIZE];
            end
        end
        if (state == S_R && axi.rvalid)
            line_buf[beat] <= axi.rdata;
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: randomized AXI slave and cache
// stimulus against a transaction-level model, plus directed scenarios.
module tb_cache_axi_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BS = 6;
    localparam int BLOCKS = (2**BS) / (DW/8);
    localparam int LW = 8 * (2**BS);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic addr_valid_in = 1'b0;
    logic addr_ready;
    logic [AW-1:0] addr_in = '0;
    logic rw_in = 1'b0;
    logic valid_wb = 1'b0;
    logic ready_wb;
    logic [LW-1:0] data_wb = '0;
    logic valid_ld;
    logic ready_ld = 1'b0;
    logic [LW-1:0] data_ld;
    logic bus_err;

    cache_axi_bridge_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) axi ();

    cache_axi_bridge #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_valid_in(addr_valid_in), .addr_ready(addr_ready), .addr_in(addr_in),
        .rw_in(rw_in), .valid_wb(valid_wb), .ready_wb(ready_wb), .data_wb(data_wb),
        .valid_ld(valid_ld), .ready_ld(ready_ld), .data_ld(data_ld),
        .bus_err(bus_err), .axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model state.
    bit m_active = 0, m_wr = 0, m_aw_done = 0, m_ar_done = 0, m_err = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wline [BLOCKS];
    logic [DW-1:0] m_rline [BLOCKS];
    int m_w_cnt = 0, m_r_cnt = 0;

    // Observations of the DUT for directed literal checks.
    int cyc = 0, acc_cyc = 0, arv_cyc = -1, ld_cyc = -1;
    bit acc_flag = 0;
    int rwb_cnt = 0, w_hs = 0, wlast_hs = 0, r_hs = 0, ld_cnt = 0, aw_seen = 0, ld_vcnt = 0;
    logic [AW-1:0] ar_addr_seen = '0, aw_addr_seen = '0;
    logic [DW-1:0] w_first = '0, w_final = '0;
    logic [DW-1:0] ld_word [BLOCKS];

    // Slave / cache-side stimulus knobs.
    int rdy_pct = 100, aw_block = 0, ld_block = 0;
    int rresp_err_beat = -1, rlast_bad_beat = -1;
    bit wready_toggle = 0, rdata_rand = 0, rand_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    function automatic bit rnd_rdy();
        return ($urandom_range(99) < rdy_pct);
    endfunction

    // AXI slave and cache load-acceptance stimulus, driven just after each edge.
    always begin
        @(posedge clk);
        #1;
        if (aw_block > 0) begin axi.awready = 1'b0; aw_block--; end
        else axi.awready = rnd_rdy();
        if (wready_toggle) axi.wready = !axi.wready;
        else axi.wready = rnd_rdy();
        axi.bvalid  = rnd_rdy();
        axi.bresp   = (rand_err && $urandom_range(15) == 0) ? 2'b10 : 2'b00;
        axi.arready = rnd_rdy();
        axi.rvalid  = rnd_rdy();
        axi.rdata   = rdata_rand ? DW'($urandom) : DW'(m_r_cnt);
        axi.rresp   = (m_r_cnt == rresp_err_beat || (rand_err && $urandom_range(31) == 0)) ? 2'b10 : 2'b00;
        axi.rlast   = (m_r_cnt == BLOCKS-1) || (m_r_cnt == rlast_bad_beat);
        if (ld_block > 0 && valid_ld) begin ready_ld = 1'b0; ld_block--; end
        else ready_ld = rnd_rdy();
    end

    // Compare process: checks DUT outputs against the model each cycle, then
    // advances the model by the handshakes that the coming edge will complete.
    always @(negedge clk) begin
        bit e_awv, e_wv, e_bre, e_arv, e_rre, e_vld, acc;
        cyc++;
        if (!rst_n) begin
            m_active = 0; m_err = 0; m_aw_done = 0; m_ar_done = 0;
            m_w_cnt = 0; m_r_cnt = 0;
        end else begin
            e_awv = m_active && m_wr && !m_aw_done;
            e_wv  = m_active && m_wr && m_aw_done && m_w_cnt < BLOCKS;
            e_bre = m_active && m_wr && m_w_cnt == BLOCKS;
            e_arv = m_active && !m_wr && !m_ar_done;
            e_rre = m_active && !m_wr && m_ar_done && m_r_cnt < BLOCKS;
            e_vld = m_active && !m_wr && m_r_cnt == BLOCKS;
            acc   = !m_active && addr_valid_in && (!rw_in || valid_wb);

            chk("addr_ready", addr_ready, !m_active);
            chk("ready_wb", ready_wb, !m_active && addr_valid_in && rw_in && valid_wb);
            chk("awvalid", axi.awvalid, e_awv);
            chk("wvalid", axi.wvalid, e_wv);
            chk("bready", axi.bready, e_bre);
            chk("arvalid", axi.arvalid, e_arv);
            chk("rready", axi.rready, e_rre);
            chk("valid_ld", valid_ld, e_vld);
            chk("bus_err", bus_err, m_err);
            if (e_awv) begin
                chk("awaddr", axi.awaddr, m_addr);
                chk("awlen", axi.awlen, BLOCKS-1);
                chk("awsize", axi.awsize, $clog2(DW/8));
                chk("awburst", axi.awburst, 2'b01);
            end
            if (e_wv) begin
                chk("wdata", axi.wdata, m_wline[m_w_cnt]);
                chk("wlast", axi.wlast, m_w_cnt == BLOCKS-1);
                chk("wstrb", axi.wstrb, {(DW/8){1'b1}});
            end
            if (e_arv) begin
                chk("araddr", axi.araddr, m_addr);
                chk("arlen", axi.arlen, BLOCKS-1);
                chk("arsize", axi.arsize, $clog2(DW/8));
                chk("arburst", axi.arburst, 2'b01);
            end
            if (e_vld)
                for (int k = 0; k < BLOCKS; k++)
                    chk("data_ld", data_ld[k*DW +: DW], m_rline[k]);

            // Raw DUT observations.
            rwb_cnt += int'(ready_wb);
            aw_seen += int'(axi.awvalid);
            if (axi.awvalid) aw_addr_seen = axi.awaddr;
            if (axi.arvalid && arv_cyc < 0) begin arv_cyc = cyc; ar_addr_seen = axi.araddr; end
            if (axi.wvalid && axi.wready) begin
                if (w_hs == 0) w_first = axi.wdata;
                w_final = axi.wdata;
                w_hs++;
                wlast_hs += int'(axi.wlast);
            end
            r_hs += int'(axi.rvalid && axi.rready);
            ld_vcnt += int'(valid_ld);
            if (valid_ld && ld_cyc < 0) begin
                ld_cyc = cyc;
                for (int k = 0; k < BLOCKS; k++) ld_word[k] = data_ld[k*DW +: DW];
            end
            ld_cnt += int'(valid_ld && ready_ld);

            // Model advance.
            if (e_awv && axi.awready) m_aw_done = 1;
            if (e_wv && axi.wready) m_w_cnt++;
            if (e_bre && axi.bvalid) begin
                if (axi.bresp != 2'b00) m_err = 1;
                m_active = 0;
            end
            if (e_arv && axi.arready) m_ar_done = 1;
            if (e_rre && axi.rvalid) begin
                m_rline[m_r_cnt] = axi.rdata;
                if (axi.rresp != 2'b00 || axi.rlast != (m_r_cnt == BLOCKS-1)) m_err = 1;
                m_r_cnt++;
            end
            if (e_vld && ready_ld) m_active = 0;
            if (acc) begin
                m_active = 1; m_wr = rw_in; m_aw_done = 0; m_ar_done = 0;
                m_w_cnt = 0; m_r_cnt = 0;
                m_addr = addr_in & ~AW'(2**BS - 1);
                for (int k = 0; k < BLOCKS; k++) m_wline[k] = data_wb[k*DW +: DW];
                acc_flag = 1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic clr_obs();
        acc_flag = 0; arv_cyc = -1; ld_cyc = -1;
        rwb_cnt = 0; w_hs = 0; wlast_hs = 0; r_hs = 0; ld_cnt = 0; aw_seen = 0; ld_vcnt = 0;
    endtask

    task automatic issue(input bit rw, input logic [AW-1:0] a, input logic [LW-1:0] line, input int wb_delay);
        int n;
        @(posedge clk); #1;
        acc_flag = 0;
        addr_valid_in = 1'b1; rw_in = rw; addr_in = a; data_wb = line;
        valid_wb = (wb_delay == 0);
        n = 0;
        while (!acc_flag) begin
            @(posedge clk); #1;
            if (acc_flag) break;
            n++;
            if (n >= wb_delay) valid_wb = 1'b1;
            if (n > 400) begin fail_now("accept_timeout"); break; end
        end
        addr_valid_in = 1'b0; valid_wb = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            if (!m_active) done = 1;
        end
        if (!done) fail_now("idle_timeout");
    endtask

    task automatic run(input bit rw, input logic [AW-1:0] a, input logic [LW-1:0] line, input int wb_delay);
        issue(rw, a, line, wb_delay);
        wait_idle();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] line;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_addr_ready", addr_ready, 1'b1);
        chk("reset_bus_err", bus_err, 1'b0);
        chk("reset_valid_ld", valid_ld, 1'b0);

        // Load of 0x1234 with always-ready slave returning the beat index.
        clr_obs();
        run(1'b0, 32'h0000_1234, '0, 0);
        chk("t1_araddr", ar_addr_seen, 32'h0000_1200);
        chk("t1_ar_latency", arv_cyc - acc_cyc, 1);
        chk("t1_ld_latency", ld_cyc - acc_cyc, 18);
        for (int k = 0; k < BLOCKS; k++) chk("t1_word", ld_word[k], k);

        // Write-back of 0x8000_0040 with toggling wready.
        for (int k = 0; k < BLOCKS; k++) line[k*DW +: DW] = DW'(32'hA0 + k);
        wready_toggle = 1;
        clr_obs();
        run(1'b1, 32'h8000_0040, line, 0);
        wready_toggle = 0;
        chk("t2_awaddr", aw_addr_seen, 32'h8000_0040);
        chk("t2_beats", w_hs, 16);
        chk("t2_wlast_count", wlast_hs, 1);
        chk("t2_first_beat", w_first, 32'hA0);
        chk("t2_last_beat", w_final, 32'hAF);
        chk("t2_ready_wb_pulses", rwb_cnt, 1);
        @(negedge clk);
        chk("t2_idle_after_b", addr_ready, 1'b1);

        // Write request held off by valid_wb=0 for five cycles.
        for (int k = 0; k < BLOCKS; k++) line[k*DW +: DW] = DW'($urandom);
        clr_obs();
        @(posedge clk); #1;
        addr_valid_in = 1'b1; rw_in = 1'b1; addr_in = 32'h0000_4000; data_wb = line; valid_wb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_accept", acc_flag, 1'b0);
        chk("t3_no_ready_wb", rwb_cnt, 0);
        chk("t3_no_awvalid", aw_seen, 0);
        valid_wb = 1'b1;
        @(negedge clk);
        chk("t3_ready_wb_now", ready_wb, 1'b1);
        @(posedge clk); #1;
        chk("t3_accepted", acc_flag, 1'b1);
        addr_valid_in = 1'b0; valid_wb = 1'b0;
        wait_idle();

        // awready held low; then ready_ld held low on a load.
        clr_obs();
        aw_block = 14;
        run(1'b1, 32'h0000_5080, line, 0);
        chk("t4_aw_held", aw_seen >= 11, 1'b1);
        clr_obs();
        ld_block = 4;
        rdata_rand = 1;
        run(1'b0, 32'h0000_6000, '0, 0);
        chk("t4_ld_cycles", ld_vcnt, 5);

        // Read error on beat 3, then rlast on beat 7 in a separate load.
        pulse_reset();
        rresp_err_beat = 3;
        clr_obs();
        run(1'b0, 32'h0000_2000, '0, 0);
        rresp_err_beat = -1;
        @(negedge clk);
        chk("t5_err_set", bus_err, 1'b1);
        chk("t5_beats", r_hs, 16);
        chk("t5_delivered", ld_cnt, 1);
        rlast_bad_beat = 7;
        clr_obs();
        run(1'b0, 32'h0000_3040, '0, 0);
        rlast_bad_beat = -1;
        @(negedge clk);
        chk("t5_err_sticky", bus_err, 1'b1);
        chk("t5b_beats", r_hs, 16);
        chk("t5b_delivered", ld_cnt, 1);

        // Reset during write beat 5, then a clean load.
        pulse_reset();
        issue(1'b1, 32'h0000_7000, line, 0);
        for (int i = 0; i < 200 && m_w_cnt < 5; i++) begin @(posedge clk); #1; end
        if (m_w_cnt != 5) fail_now("t6_reach_beat5");
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("t6_addr_ready", addr_ready, 1'b1);
        chk("t6_awvalid", axi.awvalid, 1'b0);
        chk("t6_wvalid", axi.wvalid, 1'b0);
        chk("t6_bus_err", bus_err, 1'b0);
        clr_obs();
        run(1'b0, 32'h0000_7000, '0, 0);
        chk("t6_load_done", ld_cnt, 1);
        chk("t6_load_beats", r_hs, 16);

        // Randomized traffic with random backpressure and occasional errors.
        rand_err = 1;
        for (int t = 0; t < 40; t++) begin
            rdy_pct = $urandom_range(100, 20);
            ld_block = $urandom_range(3);
            for (int k = 0; k < BLOCKS; k++) line[k*DW +: DW] = DW'($urandom);
            run(1'($urandom), AW'($urandom), line, $urandom_range(3));
            if ($urandom_range(9) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
